iot_event_arbiter: RTL

- Shares the single Active IoT Devices Monitor counter between N_DEV device agents.
- Each agent raises a req/on_off event. The arbiter grants one event at a time and converts it into the counter's one-cycle change/on_off strobe.
- Uses the fed-back counter_out to reject events that would underflow or overflow the count.
- Sits between device agents and the counter instance at top level.

---
 rtl/iot_mon_pkg.sv | 26 ++
 rtl/iot_event_arbiter_rr_picker.sv | 67 ++++++
 rtl/iot_event_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/iot_mon_pkg.sv
// ---------------------------------------------------------------------------
// iot_mon_pkg
// Shared types and constants for the Active IoT Devices Monitor slice.
//   state_t          : arbiter FSM states (IDLE, GRANT, HOLD)
//   DEF_N_DEV        : default number of device requesters
//   DEF_CNT_WIDTH    : default width of the monitor counter
//   cnt_max(width)   : largest value a counter of the given width can hold
// ---------------------------------------------------------------------------
package iot_mon_pkg;

  localparam int DEF_N_DEV     = 4;
  localparam int DEF_CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Computed in 64 bits so the shift stays well defined for any counter width
  // the monitor is likely to use.
  function automatic longint unsigned cnt_max(input int unsigned width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/iot_event_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational winner selection for the IoT event arbiter.
//   i_req     [N_DEV]  : per-device request vector
//   i_rr_ptr  [IDX_W]  : round-robin start index (absent with ARB_FIXED_PRIO_EN)
//   o_grant   [N_DEV]  : one-hot winner, zero when no request
//   o_idx     [IDX_W]  : binary index of the winner
//   o_valid            : at least one request present
// Configuration macro: ARB_FIXED_PRIO_EN turns the picker into a plain
// lowest-index-wins priority encoder.
// ---------------------------------------------------------------------------
module rr_picker
  import iot_mon_pkg::*;
#(
  parameter int N_DEV = DEF_N_DEV,
  parameter int IDX_W = $clog2(N_DEV)
) (
  input  logic [N_DEV-1:0] i_req,
`ifndef ARB_FIXED_PRIO_EN
  input  logic [IDX_W-1:0] i_rr_ptr,
`endif
  output logic [N_DEV-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  assign o_valid = |i_req;

`ifdef ARB_FIXED_PRIO_EN
  // Scanning downwards lets the lowest set index overwrite any higher one.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    for (int i = N_DEV - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_grant    = '0;
        o_grant[i] = 1'b1;
        o_idx      = IDX_W'(i);
      end
    end
  end
`else
  logic w_found;
  int   w_pos;

  // Walk the devices starting at the pointer, wrapping once past N_DEV-1;
  // the first requester met is the winner.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int off = 0; off < N_DEV; off++) begin
      w_pos = int'(i_rr_ptr) + off;
      if (w_pos >= N_DEV) begin
        w_pos = w_pos - N_DEV;
      end
      if (!w_found && i_req[w_pos]) begin
        w_found        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = IDX_W'(w_pos);
      end
    end
  end
`endif

endmodule

// File: rtl/iot_event_arbiter.sv
// ---------------------------------------------------------------------------
// iot_event_arbiter
// Shares one Active IoT Devices Monitor counter between N_DEV device agents.
// One event is granted at a time and turned into the counter's one-cycle
// change/on_off strobe; events that would wrap the count are rejected.
//   clk, rst            : clock (rising edge), async active-high reset
//   dev_req    [N_DEV]  : per-device event request (level)
//   dev_on_off [N_DEV]  : per-device direction, 1 = +1, 0 = -1
//   counter_out[CNT_W]  : current count fed back from the counter
//   change              : one-cycle strobe, apply on_off this cycle
//   on_off              : direction to the counter, valid with change
//   dev_ack    [N_DEV]  : one-hot pulse, event applied
//   dev_err    [N_DEV]  : one-hot pulse, event rejected (saturation)
//   busy                : high in GRANT and HOLD
// Configuration macro: ARB_FIXED_PRIO_EN selects fixed lowest-index priority
// instead of round-robin (no rr_ptr register in that build).
// ---------------------------------------------------------------------------
module iot_event_arbiter
  import iot_mon_pkg::*;
#(
  parameter int N_DEV     = DEF_N_DEV,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_DEV-1:0]     dev_req,
  input  logic [N_DEV-1:0]     dev_on_off,
  input  logic [CNT_WIDTH-1:0] counter_out,
  output logic                 change,
  output logic                 on_off,
  output logic [N_DEV-1:0]     dev_ack,
  output logic [N_DEV-1:0]     dev_err,
  output logic                 busy
);

  localparam int                   IDX_W     = $clog2(N_DEV);
  localparam logic [CNT_WIDTH-1:0] L_CNT_MAX = CNT_WIDTH'(cnt_max(CNT_WIDTH));

  state_t             r_state;
  logic               r_change;
  logic               r_on_off;
  logic [N_DEV-1:0]   r_ack;
  logic [N_DEV-1:0]   r_err;
  logic               r_busy;

  logic [N_DEV-1:0]   w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic               w_valid;
  logic               w_dir;
  logic               w_reject;

`ifndef ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_ptr_next;
  logic [IDX_W-1:0]   w_ptr_next;
`endif

  rr_picker #(
    .N_DEV (N_DEV),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_req    (dev_req),
`ifndef ARB_FIXED_PRIO_EN
    .i_rr_ptr (r_rr_ptr),
`endif
    .o_grant  (w_grant),
    .o_idx    (w_idx),
    .o_valid  (w_valid)
  );

  // The saturation check looks at the winner's direction against the count
  // as it stands now; HOLD guarantees this count already reflects the
  // previous strobe.
  assign w_dir    = dev_on_off[w_idx];
  assign w_reject = w_dir ? (counter_out == L_CNT_MAX) : (counter_out == '0);

`ifndef ARB_FIXED_PRIO_EN
  assign w_ptr_next = (w_idx == IDX_W'(N_DEV - 1)) ? '0 : w_idx + 1'b1;
`endif

  // Outputs are registered, so the strobe/ack values for the GRANT cycle are
  // loaded on the IDLE->GRANT edge; this gives the one-cycle request latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_change <= 1'b0;
      r_on_off <= 1'b0;
      r_ack    <= '0;
      r_err    <= '0;
      r_busy   <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      r_rr_ptr   <= '0;
      r_ptr_next <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_state  <= GRANT;
            r_busy   <= 1'b1;
            r_change <= !w_reject;
            r_on_off <= w_dir;
            r_ack    <= w_reject ? '0 : w_grant;
            r_err    <= w_reject ? w_grant : '0;
`ifndef ARB_FIXED_PRIO_EN
            r_ptr_next <= w_ptr_next;
`endif
          end
        end
        GRANT: begin
          r_state  <= HOLD;
          r_change <= 1'b0;
          r_on_off <= 1'b0;
          r_ack    <= '0;
          r_err    <= '0;
`ifndef ARB_FIXED_PRIO_EN
          r_rr_ptr <= r_ptr_next;
`endif
        end
        HOLD: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state  <= IDLE;
          r_busy   <= 1'b0;
          r_change <= 1'b0;
          r_on_off <= 1'b0;
          r_ack    <= '0;
          r_err    <= '0;
        end
      endcase
    end
  end

  assign change  = r_change;
  assign on_off  = r_on_off;
  assign dev_ack = r_ack;
  assign dev_err = r_err;
  assign busy    = r_busy;

endmodule
